sram_mp_arbiter: RTL

Parametrised multi-port controller that time-multiplexes NPORTS independent request/acknowledge clients onto one asynchronous single-port SRAM (address bus, bidirectional data bus, ce_n/oe_n/we_n). It succeeds the fixed two-port, 10-bit-address, 8-bit-data controller.

- Adds per-port handshakes, round-robin arbitration, configurable wait states and registered read data.
- Sits between the CPU, video and peripheral masters and the board SRAM pins.

---
 rtl/sram_mp_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sram_mp_arbiter.sv
// Multi-port round-robin controller sharing one asynchronous single-port SRAM among NPORTS clients.
// Build macro SRAM_ARB_FIXED_PRIORITY_EN holds the priority pointer at port 0 (fixed priority).
module sram_mp_arbiter #(
    parameter int NPORTS      = 2,
    parameter int AW          = 19,
    parameter int DW          = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*DW-1:0] din,
    output logic [NPORTS*DW-1:0] dout,
    output logic [NPORTS-1:0]    ack,
    output logic [AW-1:0]        sram_a,
    inout  wire  [DW-1:0]        sram_d,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n
);
    localparam int PW = $clog2(NPORTS);
    localparam int CW = $clog2(WAIT_STATES + 1);
    localparam logic [PW:0]   NP_W   = (PW + 1)'(NPORTS);
    localparam logic [PW-1:0] LAST_P = PW'(NPORTS - 1);
    localparam logic [CW-1:0] LAST_W = CW'(WAIT_STATES - 1);
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                r_state, w_state;
    logic [PW-1:0]         r_cur, w_cur, r_ptr, w_ptr, w_cur_inc, w_base, w_idx;
    logic [CW-1:0]         r_wcnt, w_wcnt;
    logic [NPORTS-1:0]     w_mask, r_ack, w_ack;
    logic                  w_hit, r_wr, w_wr;
    logic [AW-1:0]         r_sram_a, w_sram_a;
    logic [DW-1:0]         r_wdata, w_wdata;
    logic                  r_ce_n, w_ce_n, r_oe_n, w_oe_n, r_we_n, w_we_n, r_drive, w_drive;
    logic [NPORTS*DW-1:0]  r_dout, w_dout;

    // Returns {hit, index} of the first set mask bit at or after base, wrapping around.
    function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] mask, input logic [PW-1:0] base);
        logic [PW:0] idx;
        logic [PW:0] res;
        res = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            idx = {1'b0, base} + (PW + 1)'(k);
            if (idx >= NP_W) begin
                idx = idx - NP_W;
            end
            if (mask[idx[PW-1:0]]) begin
                res = {1'b1, idx[PW-1:0]};
            end
        end
        return res;
    endfunction

    // Next-state, arbitration and next-value logic for every registered output.
    always_comb begin
        w_state  = r_state;
        w_cur    = r_cur;
        w_ptr    = r_ptr;
        w_wcnt   = r_wcnt;
        w_wr     = r_wr;
        w_sram_a = r_sram_a;
        w_wdata  = r_wdata;
        w_ce_n   = r_ce_n;
        w_drive  = r_drive;
        w_oe_n   = 1'b1;
        w_we_n   = 1'b1;
        w_ack    = '0;
        w_dout   = r_dout;
        w_cur_inc = (r_cur == LAST_P) ? '0 : r_cur + PW'(1);
        // DONE re-arbitrates excluding the port just served, starting after it.
        if (r_state == ST_DONE) begin
            w_mask = req & ~({{(NPORTS-1){1'b0}}, 1'b1} << r_cur);
            w_base = FIXED_PRIO ? '0 : w_cur_inc;
        end else begin
            w_mask = req;
            w_base = r_ptr;
        end
        {w_hit, w_idx} = rr_pick(w_mask, w_base);

        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_state = ST_SETUP;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state = ST_ACCESS;
                w_wcnt  = '0;
                w_oe_n  = r_wr;
                w_we_n  = ~r_wr;
            end
            ST_ACCESS: begin
                if (r_wcnt == LAST_W) begin
                    w_state      = ST_DONE;
                    w_ack[r_cur] = 1'b1;
                    if (!r_wr) begin
                        w_dout[int'(r_cur)*DW +: DW] = sram_d;
                    end else begin
                        w_dout = r_dout;
                    end
                end else begin
                    w_wcnt = r_wcnt + CW'(1);
                    w_oe_n = r_wr;
                    w_we_n = ~r_wr;
                end
            end
            ST_DONE: begin
                w_ptr = w_base;
                if (w_hit) begin
                    w_state = ST_SETUP;
                end else begin
                    w_state = ST_IDLE;
                    w_ce_n  = 1'b1;
                    w_drive = 1'b0;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_ce_n  = 1'b1;
                w_drive = 1'b0;
            end
        endcase

        if (w_state == ST_SETUP) begin
            w_cur    = w_idx;
            w_wr     = we[w_idx];
            w_sram_a = addr[int'(w_idx)*AW +: AW];
            w_wdata  = din[int'(w_idx)*DW +: DW];
            w_ce_n   = 1'b0;
            w_drive  = we[w_idx];
        end else begin
            w_cur = w_cur;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cur    <= '0;
            r_ptr    <= '0;
            r_wcnt   <= '0;
            r_wr     <= 1'b0;
            r_sram_a <= '0;
            r_wdata  <= '0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_drive  <= 1'b0;
            r_ack    <= '0;
            r_dout   <= '0;
        end else begin
            r_state  <= w_state;
            r_cur    <= w_cur;
            r_ptr    <= w_ptr;
            r_wcnt   <= w_wcnt;
            r_wr     <= w_wr;
            r_sram_a <= w_sram_a;
            r_wdata  <= w_wdata;
            r_ce_n   <= w_ce_n;
            r_oe_n   <= w_oe_n;
            r_we_n   <= w_we_n;
            r_drive  <= w_drive;
            r_ack    <= w_ack;
            r_dout   <= w_dout;
        end
    end

    assign sram_a    = r_sram_a;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign ack       = r_ack;
    assign dout      = r_dout;
    assign sram_d    = r_drive ? r_wdata : {DW{1'bz}};

endmodule
